net_rtt_avg: RTL
================

# net_rtt_avg

Averaging front-end for the network timing path. It accumulates round-trip-time samples and, on request, drives the pipelined divider (`net_div_r`) with sum/count. It captures the quotient and remainder, applies optional round-half-up, and presents the mean.
- It sits directly upstream of the divider and also consumes the divider's result.
- Sample accumulation continues while a division is in flight.

## Interface
Parameters:
- `DW`, 32, sample/sum/result width; must equal the divider's `DW`.
- `CW`, 8, sample-counter width; `CW <= DW`.
- `ROUND`, 1, 1 = round half up, 0 = truncate.
- `TO_CYC`, 64, watchdog limit in cycles, counted from `div_start_o` to `div_end_i`.

Ports (reset values in brackets):
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `clr_i`  in  1  clears accumulator and `ovf_o`.
- `smp_vld_i`  in  1  sample strobe.
- `smp_dt_i`  in  DW  RTT sample, unsigned.
- `calc_i`  in  1  request an average.
- `div_ready_i`  in  1  divider idle.
- `div_end_i`  in  1  divider result valid.
- `div_q_i`  in  DW  divider quotient.
- `div_r_i`  in  DW  divider remainder.
- `div_start_o`  out  1  one-cycle divider start [0].
- `div_a_o`  out  DW  dividend = snapshot sum [0].
- `div_b_o`  out  DW  divisor = zero-extended snapshot count [0].
- `busy_o`  out  1  FSM not IDLE [0].
- `avg_vld_o`  out  1  one-cycle result pulse [0].
- `avg_o`  out  DW  mean, held until the next result [0].
- `avg_rem_o`  out  DW  raw remainder [0].
- `cnt_o`  out  CW  live sample count [0].
- `ovf_o`  out  1  sticky saturation flag [0].
- `err_o`  out  1  one-cycle error pulse (empty calc or timeout) [0].

## Operation
Accumulator (runs independently of the FSM):
- On `smp_vld_i`: `sum += smp_dt_i` and `cnt += 1`.
- Sum overflow (carry out of DW bits): sum saturates to all-ones and `ovf_o` is set.
- Count at `2^CW-1`: the sample is dropped entirely and `ovf_o` is set.
- `clr_i` has priority: sum, count and `ovf_o` go to 0, and a same-cycle sample is dropped.

FSM states: IDLE, WAIT_RDY, START, WAIT_END.
- **IDLE**, `calc_i` and `cnt==0`: pulse `err_o`, stay in IDLE.
- **IDLE**, `calc_i` and `cnt>0` and no `clr_i`:
  - latch `div_a_o <= sum` and `div_b_o <= cnt`;
  - clear the accumulator (a same-cycle sample starts the new accumulation, `cnt=1`);
  - go to WAIT_RDY.
- **IDLE**, `calc_i` together with `clr_i`: the calc is ignored.
- **WAIT_RDY**: when `div_ready_i` is sampled high, go to START.
- **START**: `div_start_o=1` for exactly this cycle; clear the watchdog; go to WAIT_END.
- **WAIT_END**, `div_end_i`:
  - `avg_rem_o <= div_r_i`;
  - `avg_o <= div_q_i + (ROUND && 2*div_r_i >= div_b_o)`, saturating at all-ones; compute `2*r` in DW+1 bits;
  - `avg_vld_o` pulses next cycle; go to IDLE.
- **WAIT_END**, watchdog reaches `TO_CYC`: pulse `err_o`, go to IDLE, `avg_o` unchanged.

Other rules:
- `calc_i` outside IDLE is ignored. `clr_i` outside IDLE touches only the accumulator.
- `div_a_o`/`div_b_o` stay stable from WAIT_RDY until the next snapshot.

## Timing
- Every output is registered.
- `calc_i` sampled at edge t: `busy_o=1` from t+1; `div_start_o` high in cycle t+2 if `div_ready_i` is already high.
- With a divider of `N_PIPE` stages, `div_end_i` arrives at t+2+N_PIPE.
  - `avg_vld_o` and the new `avg_o` appear at t+3+N_PIPE.
  - `busy_o` falls at the same edge.
- Back-to-back: `calc_i` is accepted in the cycle after `busy_o` falls.
- `rst_i` in any state: FSM to IDLE and all outputs to reset values on the next edge. There is no divider abort; a pending `div_end_i` arriving after reset is ignored because the FSM is in IDLE.

## Structure
- Package `net_avg_pkg`: FSM state enum, `avg_st_t`.
- Sub-module `net_avg_acc`: saturating sum/count accumulator with clear priority, about 60 lines.
- Top level: FSM, snapshot, watchdog, rounding.
- The divider is instantiated beside this block by the parent, not inside it.

## Test plan
- **Basic average:** samples 10, 20, 30, 41 then `calc_i`.
  - `div_a_o=101`, `div_b_o=4`, one `div_start_o`.
  - `avg_o=25`, `avg_rem_o=1`, one `avg_vld_o`.
- **Rounding:** samples 5, 6.
  - `ROUND=1`: `avg_o=6`.
  - `ROUND=0`: `avg_o=5`, `avg_rem_o=1`.
- **Empty calc:** `calc_i` with `cnt=0`: `err_o` pulses once, `busy_o` stays 0, `div_start_o` stays 0.
- **Saturation:** samples 0xFFFF_FFF0 then 0x20.
  - Sum = 0xFFFF_FFFF, `ovf_o=1`.
  - `clr_i` returns `ovf_o=0`, `cnt_o=0`.
- **Snapshot overlap:** sample 7 in the same cycle as `calc_i`, plus 3 more samples during WAIT_END.
  - Result uses the old set only.
  - `cnt_o=4` after completion.
- **Faults and ready stall:**
  - Hold `div_end_i` low: `err_o` pulses 64 cycles after START, FSM returns to IDLE.
  - Hold `div_ready_i` low for 10 cycles: start is delayed by exactly 10 cycles.
  - Assert `rst_i` mid-WAIT_END: all outputs return to 0.

Source files
------------

// File: rtl/net_avg_pkg.sv
// Shared types for the RTT averaging front-end.
// FSM state encoding used by the top level.
package net_avg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    START,
    WAIT_END
  } avg_st_t;

endpackage

// File: rtl/net_rtt_avg_if.sv
// Divider handshake bundle between the averager and net_div_r.
// master = averager side, slave = divider side.
interface net_rtt_avg_if #(
  parameter int DW = 32
);

  logic          div_start_o;
  logic [DW-1:0] div_a_o;
  logic [DW-1:0] div_b_o;
  logic          div_ready_i;
  logic          div_end_i;
  logic [DW-1:0] div_q_i;
  logic [DW-1:0] div_r_i;

  modport master (
    output div_start_o,
    output div_a_o,
    output div_b_o,
    input  div_ready_i,
    input  div_end_i,
    input  div_q_i,
    input  div_r_i
  );

  modport slave (
    input  div_start_o,
    input  div_a_o,
    input  div_b_o,
    output div_ready_i,
    output div_end_i,
    output div_q_i,
    output div_r_i
  );

endinterface

// File: rtl/net_avg_acc.sv
// Saturating RTT sum/count accumulator.
// Clear wins over everything; snapshot restarts from the same-cycle sample.
module net_avg_acc #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          snap_i,
  input  logic          smp_vld_i,
  input  logic [DW-1:0] smp_dt_i,
  output logic [DW-1:0] sum_o,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [DW:0] add;

  assign add = {1'b0, sum_o} + {1'b0, smp_dt_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      sum_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (snap_i) begin
      sum_o <= smp_vld_i ? smp_dt_i : '0;
      cnt_o <= smp_vld_i ? CW'(1) : '0;
    end else if (smp_vld_i) begin
      // a full counter drops the sample, sum included
      if (&cnt_o) begin
        ovf_o <= 1'b1;
      end else begin
        cnt_o <= cnt_o + CW'(1);
        if (add[DW]) begin
          sum_o <= '1;
          ovf_o <= 1'b1;
        end else begin
          sum_o <= add[DW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/net_rtt_avg.sv
// RTT averager: snapshots sum/count, drives the divider,
// rounds the quotient and presents the mean.
module net_rtt_avg
  import net_avg_pkg::*;
#(
  parameter int DW     = 32,
  parameter int CW     = 8,
  parameter int ROUND  = 1,
  parameter int TO_CYC = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          smp_vld_i,
  input  logic [DW-1:0] smp_dt_i,
  input  logic          calc_i,
  net_rtt_avg_if.master div,
  output logic          busy_o,
  output logic          avg_vld_o,
  output logic [DW-1:0] avg_o,
  output logic [DW-1:0] avg_rem_o,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o,
  output logic          err_o
);

  localparam int WW = $clog2(TO_CYC + 1);

  avg_st_t       st;
  avg_st_t       nxt;
  logic [WW-1:0] wd;
  logic [DW-1:0] sum;
  logic          snap;
  logic          err_n;
  logic          res_ld;
  logic          up;
  logic [DW:0]   r2;
  logic [DW:0]   qs;
  logic [DW-1:0] rnd;

  net_avg_acc #(
    .DW(DW),
    .CW(CW)
  ) u_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_i),
    .snap_i   (snap),
    .smp_vld_i(smp_vld_i),
    .smp_dt_i (smp_dt_i),
    .sum_o    (sum),
    .cnt_o    (cnt_o),
    .ovf_o    (ovf_o)
  );

  // 2*r kept one bit wider so a large remainder cannot wrap
  assign r2  = {div.div_r_i, 1'b0};
  assign up  = (ROUND != 0) && (r2 >= {1'b0, div.div_b_o});
  assign qs  = {1'b0, div.div_q_i} + {{DW{1'b0}}, up};
  assign rnd = qs[DW] ? '1 : qs[DW-1:0];

  always_comb begin
    nxt    = st;
    snap   = 1'b0;
    err_n  = 1'b0;
    res_ld = 1'b0;
    unique case (st)
      IDLE: begin
        if (calc_i && !clr_i) begin
          if (cnt_o == '0) begin
            err_n = 1'b1;
          end else begin
            snap = 1'b1;
            nxt  = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (div.div_ready_i) nxt = START;
      end
      START: begin
        nxt = WAIT_END;
      end
      WAIT_END: begin
        if (div.div_end_i) begin
          res_ld = 1'b1;
          nxt    = IDLE;
        end else if (wd == WW'(TO_CYC - 1)) begin
          err_n = 1'b1;
          nxt   = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st              <= IDLE;
      wd              <= '0;
      busy_o          <= 1'b0;
      avg_vld_o       <= 1'b0;
      avg_o           <= '0;
      avg_rem_o       <= '0;
      err_o           <= 1'b0;
      div.div_start_o <= 1'b0;
      div.div_a_o     <= '0;
      div.div_b_o     <= '0;
    end else begin
      st              <= nxt;
      busy_o          <= (nxt != IDLE);
      div.div_start_o <= (nxt == START);
      avg_vld_o       <= res_ld;
      err_o           <= err_n;
      if (snap) begin
        div.div_a_o <= sum;
        div.div_b_o <= DW'(cnt_o);
      end
      // wd counts cycles since div_start_o rose, start cycle included
      if (st == START) begin
        wd <= WW'(1);
      end else if (st == WAIT_END) begin
        wd <= wd + WW'(1);
      end
      if (res_ld) begin
        avg_o     <= rnd;
        avg_rem_o <= div.div_r_i;
      end
    end
  end

endmodule
